// File: rtl/io_uart_pkg.sv
// Shared constants for the io_uart_tx block: register offsets, STATUS/CTRL
// bit positions, FSM state encoding and a parity helper.
// The parity state is only reachable when IO_UART_TX_PARITY_EN is defined.
package io_uart_pkg;

    // Register word offsets, selected by io_address[3:2]
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_FULL    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    // CTRL bit positions
    localparam int CTRL_EN    = 0;
    localparam int CTRL_FLUSH = 1;
    localparam int CTRL_PODD  = 2;

    // Transmit FSM state encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;

    // Even parity over one data byte
    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/io_uart_fifo.sv
// Byte FIFO for the UART transmitter. Head data is visible combinationally.
// A push while full is dropped (even with a simultaneous pop); flush wins
// over push and pop in the same cycle.
module io_uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 wr_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [7:0]                 rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign do_push_s = push && !full && !flush;
    assign do_pop_s  = pop && !empty && !flush;

    // Storage array write; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter on the core IO bus (8N1, LSB first).
// Registers: TXDATA, STATUS, BAUD_DIV, CTRL at word offsets from BASE_ADDR.
// Optional parity (CTRL[2] = odd) is built in with IO_UART_TX_PARITY_EN.
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_value,
    input  logic        io_write_en,
    input  logic        io_read_en,
    output logic [31:0] io_read_value,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          addr_hit_s, wr_hit_s, push_s, flush_s, ovf_clr_s, pop_s, load_s;
    logic [1:0]    off_s;
    logic [7:0]    fifo_head_s;
    logic          fifo_full_s, fifo_empty_s, busy_s, wrap_s, tx_nx;
    logic [CW-1:0] fifo_count_s;
    logic [15:0]   baud_r, div_r, div_nx, cnt_r, cnt_nx;
    logic          en_r, ovf_r, tx_r;
    logic [2:0]    state_r, state_nx, bit_r, bit_nx;
    logic [7:0]    shift_r, shift_nx;
    logic [31:0]   status_s, ctrl_rd_s, rdata_s;
    logic          unused_s;
`ifdef IO_UART_TX_PARITY_EN
    logic          podd_r, par_r, par_nx;
`endif

    assign unused_s   = ^{io_write_value[31:16], io_address[1:0]};
    assign addr_hit_s = (io_address[31:4] == BASE_ADDR[31:4]);
    assign off_s      = io_address[3:2];
    assign wr_hit_s   = io_write_en && addr_hit_s;
    assign push_s     = wr_hit_s && (off_s == OFF_TXDATA);
    assign flush_s    = wr_hit_s && (off_s == OFF_CTRL) && io_write_value[CTRL_FLUSH];
    assign ovf_clr_s  = wr_hit_s && (off_s == OFF_STATUS) && io_write_value[ST_OVF];
    assign busy_s     = (state_r != S_IDLE);
    assign wrap_s     = (cnt_r == div_r - 16'd1);
    assign tx         = tx_r;

    io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (io_write_value[7:0]),
        .pop     (pop_s),
        .flush   (flush_s),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Control/status register updates from bus writes; overflow set beats clear
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_r <= DEFAULT_DIV;
            en_r   <= 1'b1;
            ovf_r  <= 1'b0;
`ifdef IO_UART_TX_PARITY_EN
            podd_r <= 1'b0;
`endif
        end else begin
            if (wr_hit_s && (off_s == OFF_BAUD)) begin
                baud_r <= (io_write_value[15:0] == 16'd0) ? 16'd1 : io_write_value[15:0];
            end
            if (wr_hit_s && (off_s == OFF_CTRL)) begin
                en_r   <= io_write_value[CTRL_EN];
`ifdef IO_UART_TX_PARITY_EN
                podd_r <= io_write_value[CTRL_PODD];
`endif
            end
            if (push_s && fifo_full_s && !flush_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Frame sequencing: bit timing, shifting, and back-to-back frame loading
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        bit_nx   = bit_r;
        shift_nx = shift_r;
        div_nx   = div_r;
        load_s   = 1'b0;
        pop_s    = 1'b0;
`ifdef IO_UART_TX_PARITY_EN
        par_nx   = par_r;
`endif
        case (state_r)
            S_IDLE: begin
                cnt_nx = 16'd0;
                load_s = en_r && !fifo_empty_s;
            end
            S_START: begin
                if (wrap_s) begin
                    cnt_nx   = 16'd0;
                    bit_nx   = 3'd0;
                    state_nx = S_DATA;
                end else begin
                    cnt_nx = cnt_r + 16'd1;
                end
            end
            S_DATA: begin
                if (wrap_s) begin
                    cnt_nx   = 16'd0;
                    shift_nx = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        bit_nx = 3'd0;
`ifdef IO_UART_TX_PARITY_EN
                        state_nx = S_PARITY;
`else
                        state_nx = S_STOP;
`endif
                    end else begin
                        bit_nx = bit_r + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt_r + 16'd1;
                end
            end
`ifdef IO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (wrap_s) begin
                    cnt_nx   = 16'd0;
                    state_nx = S_STOP;
                end else begin
                    cnt_nx = cnt_r + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (wrap_s) begin
                    cnt_nx   = 16'd0;
                    state_nx = S_IDLE;
                    load_s   = en_r && !fifo_empty_s;
                end else begin
                    cnt_nx = cnt_r + 16'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 16'd0;
            end
        endcase
        if (load_s) begin
            pop_s    = 1'b1;
            state_nx = S_START;
            cnt_nx   = 16'd0;
            bit_nx   = 3'd0;
            shift_nx = fifo_head_s;
            div_nx   = baud_r;
`ifdef IO_UART_TX_PARITY_EN
            par_nx   = parity8(fifo_head_s) ^ podd_r;
`endif
        end else begin
            pop_s = 1'b0;
        end
    end

    // Line level for the upcoming cycle, so tx is a clean registered output
    always_comb begin
        case (state_nx)
            S_IDLE:   tx_nx = 1'b1;
            S_START:  tx_nx = 1'b0;
            S_DATA:   tx_nx = shift_nx[0];
`ifdef IO_UART_TX_PARITY_EN
            S_PARITY: tx_nx = par_nx;
`endif
            S_STOP:   tx_nx = 1'b1;
            default:  tx_nx = 1'b1;
        endcase
    end

    // FSM and line registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= 16'd0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            div_r   <= DEFAULT_DIV;
            tx_r    <= 1'b1;
`ifdef IO_UART_TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            bit_r   <= bit_nx;
            shift_r <= shift_nx;
            div_r   <= div_nx;
            tx_r    <= tx_nx;
`ifdef IO_UART_TX_PARITY_EN
            par_r   <= par_nx;
`endif
        end
    end

    // STATUS and CTRL read images
    always_comb begin
        status_s                      = 32'd0;
        status_s[ST_BUSY]             = busy_s;
        status_s[ST_EMPTY]            = fifo_empty_s;
        status_s[ST_FULL]             = fifo_full_s;
        status_s[ST_OVF]              = ovf_r;
        status_s[ST_CNT_LSB +: CW]    = fifo_count_s;
        ctrl_rd_s                     = 32'd0;
        ctrl_rd_s[CTRL_EN]            = en_r;
`ifdef IO_UART_TX_PARITY_EN
        ctrl_rd_s[CTRL_PODD]          = podd_r;
`endif
    end

    // Same-cycle load data; zero unless a hit read is in progress
    always_comb begin
        rdata_s = 32'd0;
        if (io_read_en && addr_hit_s) begin
            case (off_s)
                OFF_TXDATA: rdata_s = 32'd0;
                OFF_STATUS: rdata_s = status_s;
                OFF_BAUD:   rdata_s = {16'd0, baud_r};
                OFF_CTRL:   rdata_s = ctrl_rd_s;
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign io_read_value = rdata_s;

endmodule
